// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants, direction encoding and modulo helper for the counter
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Full binary range for a given width; 33 bits so WIDTH=32 still fits.
    function automatic logic [32:0] full_modulo(input int width);
        return 33'(1) << width;
    endfunction

endpackage

// File: rtl/counter_if.sv
// rtl/counter_if.sv - control, load and status bundle between a counter and its user
interface counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  count, tc, wrap
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output count, tc, wrap
    );

endinterface

// File: rtl/counter.sv
// rtl/counter.sv - modulo-N up/down counter with clear, saturating load, terminal count and wrap pulse
module counter
    import counter_pkg::*;
#(
    parameter int          WIDTH     = DEFAULT_WIDTH,
    parameter logic [32:0] MODULO    = full_modulo(WIDTH),
    parameter int unsigned RESET_VAL = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    counter_if.slave bus
);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    logic [WIDTH:0]   w_modulo;
    logic [WIDTH-1:0] w_max;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_next;

    assign w_modulo  = MODULO[WIDTH:0];
    assign w_max     = WIDTH'(MODULO - 33'd1);
    assign w_inc     = {1'b0, r_count} + (WIDTH+1)'(1);
    assign w_dec     = {1'b0, r_count} - (WIDTH+1)'(1);
    // Wide compare/borrow keep non-power-of-two moduli exact.
    assign w_at_max  = (w_inc == w_modulo);
    assign w_at_zero = w_dec[WIDTH];

    always_comb begin
        w_next      = r_count;
        w_wrap_next = 1'b0;
        if (bus.clr) begin
            w_next = '0;
        end else if (bus.load) begin
            w_next = (bus.load_val > w_max) ? w_max : bus.load_val;
        end else if (bus.en) begin
            if (dir_e'(bus.up_dn) == DIR_UP) begin
                w_next      = w_at_max ? '0 : w_inc[WIDTH-1:0];
                w_wrap_next = w_at_max;
            end else begin
                w_next      = w_at_zero ? w_max : w_dec[WIDTH-1:0];
                w_wrap_next = w_at_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= WIDTH'(RESET_VAL);
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign bus.count = r_count;
    assign bus.wrap  = r_wrap;
    assign bus.tc    = (dir_e'(bus.up_dn) == DIR_UP) ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - scoreboard bench for counter: default modulo-16 and modulo-10 instances
module tb_counter;
    import counter_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    counter_if #(.WIDTH(4)) bus_a ();
    counter_if #(.WIDTH(4)) bus_b ();

    counter #(.WIDTH(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    counter #(.WIDTH(4), .MODULO(33'd10)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        logic [3:0] count;
        logic       tc;
        logic       wrap;
        string      tag;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   vectors     = 0;
    int   miscompares = 0;
    event ev_chk;

    task automatic check(input string dut, input logic [3:0] c, input logic t,
                         input logic w, input exp_t e);
        vectors++;
        if (c !== e.count || t !== e.tc || w !== e.wrap) begin
            miscompares++;
            $display("FAIL %s/%s: got count=%0d tc=%0b wrap=%0b, expected count=%0d tc=%0b wrap=%0b",
                     dut, e.tag, c, t, w, e.count, e.tc, e.wrap);
        end
    endtask

    // Monitor: compares after every rising edge, or on demand for async events.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or ev_chk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("A", bus_a.count, bus_a.tc, bus_a.wrap, e);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("B", bus_b.count, bus_b.tc, bus_b.wrap, e);
            end
        end
    end

    task automatic step(input logic sel, input logic rn, input logic en, input logic up,
                        input logic clr, input logic ld, input logic [3:0] lv,
                        input logic [3:0] ec, input logic et, input logic ew, input string tag);
        @(negedge clk);
        rst_n = rn;
        if (sel == L) begin
            bus_a.en = en; bus_a.up_dn = up; bus_a.clr = clr; bus_a.load = ld; bus_a.load_val = lv;
            q_a.push_back('{count: ec, tc: et, wrap: ew, tag: tag});
        end else begin
            bus_b.en = en; bus_b.up_dn = up; bus_b.clr = clr; bus_b.load = ld; bus_b.load_val = lv;
            q_b.push_back('{count: ec, tc: et, wrap: ew, tag: tag});
        end
    endtask

    initial begin
        rst_n = L;
        bus_a.en = H; bus_a.up_dn = H; bus_a.clr = L; bus_a.load = L; bus_a.load_val = 4'd0;
        bus_b.en = L; bus_b.up_dn = H; bus_b.clr = L; bus_b.load = L; bus_b.load_val = 4'd0;

        @(negedge clk);
        #2;
        q_a.push_back('{count: 4'd0, tc: L, wrap: L, tag: "reset"});
        -> ev_chk;

        for (int i = 1; i <= 16; i++)
            step(L, H, H, H, L, L, 4'd0, 4'(i % 16), (i % 16) == 15, i == 16, "free_run");

        step(L, H, L, L, L, L, 4'd0, 4'd0,  H, L, "hold_dn_tc");
        step(L, H, H, L, L, L, 4'd0, 4'd15, L, H, "dn_wrap");
        step(L, H, H, L, L, L, 4'd0, 4'd14, L, L, "dn_14");
        step(L, H, H, L, L, L, 4'd0, 4'd13, L, L, "dn_13");

        step(L, H, L, H, L, H, 4'd5, 4'd5, L, L, "load5");
        step(L, H, H, H, H, H, 4'd7, 4'd0, L, L, "prio_clr");
        step(L, H, H, H, L, H, 4'd7, 4'd7, L, L, "prio_load");
        for (int i = 0; i < 3; i++)
            step(L, H, L, H, L, L, 4'd0, 4'd7, L, L, "hold7");

        step(L, H, L, H, H, L, 4'd0, 4'd0, L, L, "clr");
        for (int k = 0; k < 5; k++)
            step(L, H, (k % 2) == 0, H, L, L, 4'd0, 4'(k / 2 + 1), L, L, "en_gate");

        step(L, H, L, H, L, H, 4'd11, 4'd11, L, L, "load11");
        @(negedge clk);
        #2;
        rst_n = L;
        q_a.push_back('{count: 4'd0, tc: L, wrap: L, tag: "async_rst"});
        -> ev_chk;
        step(L, L, H, H, L, L, 4'd0, 4'd0, L, L, "rst_hold");
        step(L, L, H, H, L, L, 4'd0, 4'd0, L, L, "rst_hold");
        step(L, H, H, H, L, L, 4'd0, 4'd1, L, L, "resume1");
        step(L, H, H, H, L, L, 4'd0, 4'd2, L, L, "resume2");

        for (int i = 1; i <= 10; i++)
            step(H, H, H, H, L, L, 4'd0, 4'(i % 10), (i % 10) == 9, i == 10, "m10_up");
        step(H, H, L, H, L, H, 4'd12, 4'd9, H, L, "m10_sat");
        step(H, H, H, H, L, L, 4'd0,  4'd0, L, H, "m10_wrap");
        step(H, H, H, L, L, L, 4'd0,  4'd9, L, H, "m10_dn");

        for (int k = 0; k < 20 && (q_a.size() > 0 || q_b.size() > 0); k++)
            @(posedge clk);
        #2;
        if (q_a.size() > 0 || q_b.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0",
                     q_a.size() + q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
